up_down_counter_multi: RTL

UP_DOWN_COUNTER_MULTI -- requirements
Module: up_down_counter_multi

---
 rtl/up_down_counter_pkg.sv | 17 +
 rtl/counter_channel.sv | 78 +++++++
 rtl/up_down_counter_multi.sv | 42 ++++
 3 files changed

// File: rtl/up_down_counter_pkg.sv
// Shared constants for the multi-channel up/down counter: mode encodings,
// default geometry and the per-cycle step decision used by each channel.
package up_down_counter_pkg;

  localparam int MODE_WRAP        = 0;
  localparam int MODE_SAT         = 1;
  localparam int DEFAULT_WIDTH    = 5;
  localparam int DEFAULT_CHANNELS = 2;

  typedef enum logic [1:0] {
    STEP_HOLD = 2'd0,
    STEP_LOAD = 2'd1,
    STEP_UP   = 2'd2,
    STEP_DOWN = 2'd3
  } step_e;

endpackage

// File: rtl/counter_channel.sv
// One counter channel: count register, terminal-count pulse and sticky
// overflow flag. Load beats enable; reset beats everything.
module counter_channel
  import up_down_counter_pkg::*;
#(
  parameter int               WIDTH       = DEFAULT_WIDTH,
  parameter int               SATURATE    = MODE_WRAP,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk0,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_VAL  = '1;
  localparam logic [WIDTH-1:0] MIN_VAL  = '0;
  localparam bit               SAT_MODE = (SATURATE == MODE_SAT);

  step_e            step;
  logic [WIDTH-1:0] count_nxt;
  logic             tc_nxt;

  always_comb begin
    step = STEP_HOLD;
    if (load) begin
      step = STEP_LOAD;
    end else if (en) begin
      step = up ? STEP_UP : STEP_DOWN;
    end
  end

  // A step past a limit raises tc; in saturate mode the count is simply held.
  always_comb begin
    count_nxt = count;
    tc_nxt    = 1'b0;
    unique case (step)
      STEP_LOAD: count_nxt = load_val;
      STEP_UP: begin
        if (count == MAX_VAL) begin
          tc_nxt    = 1'b1;
          count_nxt = SAT_MODE ? count : MIN_VAL;
        end else begin
          count_nxt = count + WIDTH'(1);
        end
      end
      STEP_DOWN: begin
        if (count == MIN_VAL) begin
          tc_nxt    = 1'b1;
          count_nxt = SAT_MODE ? count : MAX_VAL;
        end else begin
          count_nxt = count - WIDTH'(1);
        end
      end
      default: ;
    endcase
  end

  // A new tc event wins over a simultaneous clear of the sticky flag.
  always_ff @(posedge clk0) begin
    if (reset) begin
      count <= RESET_VALUE;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      count <= count_nxt;
      tc    <= tc_nxt;
      ovf   <= tc_nxt | (ovf & ~clr_ovf);
    end
  end

endmodule

// File: rtl/up_down_counter_multi.sv
// Multi-channel up/down counter: slices the packed buses and instantiates
// one independent counter_channel per channel.
module up_down_counter_multi
  import up_down_counter_pkg::*;
#(
  parameter int               WIDTH       = DEFAULT_WIDTH,
  parameter int               CHANNELS    = DEFAULT_CHANNELS,
  parameter int               SATURATE    = MODE_WRAP,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                      clk0,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS-1:0]       up,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS*WIDTH-1:0] load_val,
  input  logic [CHANNELS-1:0]       clr_ovf,
  output logic [CHANNELS*WIDTH-1:0] count,
  output logic [CHANNELS-1:0]       tc,
  output logic [CHANNELS-1:0]       ovf
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    counter_channel #(
      .WIDTH      (WIDTH),
      .SATURATE   (SATURATE),
      .RESET_VALUE(RESET_VALUE)
    ) u_ch (
      .clk0    (clk0),
      .reset   (reset),
      .en      (en[i]),
      .up      (up[i]),
      .load    (load[i]),
      .load_val(load_val[i*WIDTH +: WIDTH]),
      .clr_ovf (clr_ovf[i]),
      .count   (count[i*WIDTH +: WIDTH]),
      .tc      (tc[i]),
      .ovf     (ovf[i])
    );
  end

endmodule
